// File: rtl/seq_dect_ctrl.sv
// Programmable two-bit-symbol sequence detector controller.
// Holds a run-time pattern and flags overlapping matches on Z.
module seq_dect_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int CNT_W       = 8,
  parameter int MATCH_LIMIT = 0
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         cfg_we,
  input  logic [2*MAX_LEN-1:0]         cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         sym_valid,
  input  logic                         A,
  input  logic                         B,
  output logic                         Z,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MATCH_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2*MAX_LEN-1:0] pat_q, pat_d;
  logic [2*MAX_LEN-1:0] hist_q, hist_d;
  logic [2*MAX_LEN-1:0] shift_h;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        fill_q, fill_d;
  logic [LW-1:0]        fill_inc;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 z_q, z_d;
  logic                 err_q, err_d;
  logic                 len_ok;
  logic                 hit;

  // Post-shift history and match test against the active pattern
  always_comb begin
    shift_h  = {hist_q[2*MAX_LEN-3:0], A, B};
    fill_inc = (fill_q == LMAX) ? fill_q : fill_q + 1'b1;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    hit      = (fill_inc >= len_q);
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((LW'(k) < len_q) &&
          (shift_h[2*k +: 2] != pat_q[2*k +: 2]))
        hit = 1'b0;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    z_d     = 1'b0;
    err_d   = 1'b0;
    len_ok  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
        end
        len_ok = (len_d != '0) && (len_d <= LMAX);
        if (start && !stop) begin
          if (len_ok) begin
            state_d = RUN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (start) begin
          hist_d = '0;
          fill_d = '0;
          cnt_d  = '0;
        end else if (sym_valid) begin
          hist_d = shift_h;
          fill_d = fill_inc;
          if (hit) begin
            z_d   = 1'b1;
            cnt_d = cnt_inc;
            if (MATCH_LIMIT != 0 && cnt_inc == LIM)
              state_d = DONE;
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_d = IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (start) begin
          state_d = RUN;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign Z         = z_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign cfg_err   = err_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_dect_ctrl.sv
// Bench for seq_dect_ctrl: directed plan plus random traffic
// against a symbol-list reference model, unlimited and limit=2.
module tb_seq_dect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(MAX_LEN+1);
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 clr = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [2*MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]        cfg_len = '0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 sym_valid = 1'b0;
  logic                 A = 1'b0;
  logic                 B = 1'b0;

  logic             z0, busy0, done0, err0;
  logic [CNT_W-1:0] cnt0;
  logic             z1, busy1, done1, err1;
  logic [CNT_W-1:0] cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_dect_ctrl #(
    .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .MATCH_LIMIT(0)
  ) u_dut (
    .clk(clk), .clr(clr), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .start(start), .stop(stop), .sym_valid(sym_valid),
    .A(A), .B(B), .Z(z0), .busy(busy0), .done(done0),
    .cfg_err(err0), .match_cnt(cnt0)
  );

  seq_dect_ctrl #(
    .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .MATCH_LIMIT(2)
  ) u_lim (
    .clk(clk), .clr(clr), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .start(start), .stop(stop), .sym_valid(sym_valid),
    .A(A), .B(B), .Z(z1), .busy(busy1), .done(done1),
    .cfg_err(err1), .match_cnt(cnt1)
  );

  // Reference model: 0=idle 1=run 2=done; hist[0] newest
  int m_lim  [2];
  int m_st   [2];
  int m_cnt  [2];
  int m_fill [2];
  int m_len  [2];
  int m_z    [2];
  int m_err  [2];
  int m_pat  [2][MAX_LEN];
  int m_hist [2][MAX_LEN];

  function automatic void m_clear(int i);
    m_fill[i] = 0;
    for (int k = 0; k < MAX_LEN; k++) m_hist[i][k] = 0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_len[i] = 0;
      m_z[i] = 0; m_err[i] = 0;
      for (int k = 0; k < MAX_LEN; k++) m_pat[i][k] = 0;
      m_clear(i);
    end
  endfunction

  function automatic void m_step(int i);
    bit hit;
    m_z[i] = 0;
    m_err[i] = 0;
    if (m_st[i] == 0 && cfg_we) begin
      m_len[i] = int'(cfg_len);
      for (int k = 0; k < MAX_LEN; k++)
        m_pat[i][k] = int'(cfg_pattern[2*k +: 2]);
    end
    case (m_st[i])
      0: if (start && !stop) begin
        if (m_len[i] >= 1 && m_len[i] <= MAX_LEN) begin
          m_st[i] = 1; m_clear(i); m_cnt[i] = 0;
        end else m_err[i] = 1;
      end
      1: if (stop) begin
        m_st[i] = 0; m_clear(i);
      end else if (start) begin
        m_clear(i); m_cnt[i] = 0;
      end else if (sym_valid) begin
        for (int k = MAX_LEN-1; k > 0; k--)
          m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = 2*int'(A) + int'(B);
        if (m_fill[i] < MAX_LEN) m_fill[i]++;
        hit = (m_fill[i] >= m_len[i]);
        for (int k = 0; k < m_len[i]; k++)
          if (m_hist[i][k] != m_pat[i][k]) hit = 0;
        if (hit) begin
          m_z[i] = 1;
          if (m_cnt[i] < CMAX) m_cnt[i]++;
          if (m_lim[i] != 0 && m_cnt[i] == m_lim[i]) m_st[i] = 2;
        end
      end
      default: if (stop) begin
        m_st[i] = 0; m_clear(i);
      end else if (start) begin
        m_st[i] = 1; m_clear(i); m_cnt[i] = 0;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d",
               tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("z0",    int'(z0),    m_z[0]);
    chk("busy0", int'(busy0), int'(m_st[0] == 1));
    chk("done0", int'(done0), int'(m_st[0] == 2));
    chk("err0",  int'(err0),  m_err[0]);
    chk("cnt0",  int'(cnt0),  m_cnt[0]);
    chk("z1",    int'(z1),    m_z[1]);
    chk("busy1", int'(busy1), int'(m_st[1] == 1));
    chk("done1", int'(done1), int'(m_st[1] == 2));
    chk("err1",  int'(err1),  m_err[1]);
    chk("cnt1",  int'(cnt1),  m_cnt[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
    check_all();
  endtask

  task automatic load(input int len, input logic [2*MAX_LEN-1:0] pat);
    cfg_we = 1'b1;
    cfg_len = LW'(len);
    cfg_pattern = pat;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic sym(input logic [1:0] s);
    {A, B} = s;
    sym_valid = 1'b1;
    cyc();
    sym_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // first->last 01,11,00,11,10 : symbol 4 is oldest
  localparam logic [15:0] P5 = 16'b00_00_00_01_11_00_11_10;

  initial begin
    m_lim[0] = 0;
    m_lim[1] = 2;
    m_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;

    // 1: basic five-symbol match
    load(5, P5);
    go();
    sym(2'b01); sym(2'b11); sym(2'b00); sym(2'b11);
    chk("t1_noz", int'(z0), 0);
    sym(2'b10);
    chk("t1_z", int'(z0), 1);
    chk("t1_cnt", int'(cnt0), 1);
    idle(1);
    chk("t1_zoff", int'(z0), 0);

    // 2: gap between symbols 2 and 3
    go();
    sym(2'b01); sym(2'b11);
    idle(3);
    sym(2'b00); sym(2'b11); sym(2'b10);
    sym(2'b00); sym(2'b11); sym(2'b10);
    chk("t2_cnt", int'(cnt0), 1);

    // 3: overlapping len=2
    load(0, '0);
    chk("t3_idle", int'(busy0), 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    load(2, 16'h000F);
    go();
    for (int i = 0; i < 4; i++) sym(2'b11);
    chk("t3_cnt", int'(cnt0), 3);

    // 4: limit=2 instance reaches DONE
    stop = 1'b1; cyc(); stop = 1'b0;
    load(1, 16'h0002);
    go();
    sym(2'b10); sym(2'b10);
    chk("t4_done", int'(done1), 1);
    chk("t4_busy", int'(busy1), 0);
    sym(2'b10);
    chk("t4_noz", int'(z1), 0);
    go();
    chk("t4_rearm", int'(cnt1), 0);

    // 5: zero length, cfg_we in RUN, stop vs match
    stop = 1'b1; cyc(); stop = 1'b0;
    load(0, P5);
    go();
    chk("t5_err", int'(err0), 1);
    idle(1);
    chk("t5_errp", int'(err0), 0);
    load(5, P5);
    go();
    load(1, 16'h0001);
    sym(2'b01); sym(2'b11); sym(2'b00); sym(2'b11);
    stop = 1'b1;
    sym(2'b10);
    stop = 1'b0;
    chk("t5_stopz", int'(z0), 0);
    idle(1);

    // 6: async reset mid-stream
    go();
    sym(2'b01); sym(2'b11); sym(2'b00);
    #2;
    clr = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    clr = 1'b1;
    load(5, P5);
    go();
    sym(2'b01); sym(2'b11); sym(2'b00); sym(2'b11); sym(2'b10);
    chk("t6_cnt", int'(cnt0), 1);
    idle(2);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_len = ($urandom_range(0, 9) == 0) ?
                LW'($urandom_range(0, (1 << LW) - 1)) :
                LW'($urandom_range(1, 3));
      cfg_pattern = 16'($urandom);
      start = ($urandom_range(0, 24) == 0);
      stop = ($urandom_range(0, 39) == 0);
      sym_valid = ($urandom_range(0, 9) < 7);
      A = 1'($urandom);
      B = 1'($urandom);
      cyc();
    end
    cfg_we = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    sym_valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_dect_ctrl.md
Name: seq_dect_ctrl

Overview:
Programmable controller and sequencer for the two-bit-symbol (A,B) sequence detector datapath.
- Holds a run-time pattern of 1..MAX_LEN symbols and gates the symbol stream with sym_valid.
- Sequences configure → run → stop/done, flags overlapping matches on Z and counts them.
- Sits between the symbol source and downstream logic; replaces the hard-wired detector FSM when the pattern must change without re-synthesis.

Parameters:
MAX_LEN, 8, maximum pattern length in symbols (≥2)
CNT_W, 8, width of match_cnt
MATCH_LIMIT, 0, matches that end a run (DONE state); 0 = unlimited

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
cfg_we  input  1  pattern/length write strobe; honoured in IDLE only
cfg_pattern  input  2*MAX_LEN  symbol k = bits [2k+1:2k]; symbol len-1 is the first (oldest) symbol, symbol 0 the last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length in symbols
start  input  1  one-cycle start/restart pulse
stop  input  1  one-cycle abort pulse
sym_valid  input  1  A/B carry a valid symbol this cycle
A  input  1  symbol MSB
B  input  1  symbol LSB
Z  output  1  one-cycle match pulse
busy  output  1  state is RUN
done  output  1  MATCH_LIMIT reached; held
cfg_err  output  1  one-cycle pulse: start with invalid length
match_cnt  output  CNT_W  matches since last start; saturates at all-ones

Behaviour:
- Reset (clr=0, async): state IDLE.
  - Z=0, busy=0, done=0, cfg_err=0, match_cnt=0.
  - Stored pattern=0, stored len=0, history=0, fill=0.
- States: IDLE, RUN, DONE; one-hot or binary encoding is allowed.
- IDLE:
  - cfg_we=1 latches cfg_pattern and cfg_len next edge.
  - start with stored len in 1..MAX_LEN → RUN; history, fill and match_cnt cleared.
  - start with stored len 0 or >MAX_LEN → stay IDLE; cfg_err=1 for one cycle.
  - cfg_we and start in the same cycle: the write takes effect first, and start validates the new length.
- RUN:
  - busy=1; cfg_we ignored.
  - Each clk with sym_valid=1 shifts {A,B} into a MAX_LEN-deep history; newest symbol is slot 0.
  - fill increments, saturating at MAX_LEN.
  - Match condition, evaluated on the post-shift history: fill ≥ len and history slots 0..len-1 equal pattern symbols 0..len-1.
  - On a match: Z=1 in the cycle after the accepting edge (registered), for exactly one cycle; match_cnt increments by 1 (saturating).
  - Overlapping matches count; history is not flushed on a match.
  - sym_valid=0 cycles: no shift and no Z; gaps are transparent.
- RUN exits:
  - stop=1 → IDLE next edge; match_cnt retained; history and fill cleared.
  - stop has priority over a match in the same cycle: the symbol is discarded, with no Z and no count.
  - MATCH_LIMIT≠0 and the increment makes match_cnt = MATCH_LIMIT → DONE; the Z for that match still fires.
  - start in RUN: restart; counters, history and fill cleared, state stays RUN, the current symbol is discarded.
- DONE:
  - done=1, busy=0; symbols ignored; Z=0.
  - start → RUN, cleared as above, done drops.
  - stop → IDLE, done drops.
- start and stop in the same cycle: stop wins.
- len=1: every valid symbol equal to pattern symbol 0 matches.
- Async reset mid-run returns everything to reset values immediately; no Z glitch after release.

Test Plan:
1. Load len=5, pattern first→last 01,11,00,11,10; start; feed 01 11 00 11 10 with sym_valid=1 every cycle → Z high exactly one cycle after the 5th symbol edge; match_cnt=1.
2. Same pattern, stream 01 11 00 11 10 00 11 10 with sym_valid deasserted for 3 cycles between symbols 2 and 3 → single Z; no Z during the gap; match_cnt=1.
3. len=2, pattern 11,11; stream 11 11 11 11 → Z on symbols 2, 3, 4 (overlap); match_cnt=3.
4. MATCH_LIMIT=2, len=1, pattern 10; stream 10 10 10 → Z twice; done=1 and busy=0 after the second match; third symbol gives no Z; start re-arms with match_cnt=0.
5. len=0 then start → cfg_err one-cycle pulse, busy stays 0. Then:
   - cfg_we during RUN is ignored.
   - stop coincident with a matching symbol → no Z, state IDLE, match_cnt unchanged.
6. clr pulled low mid-stream with the pattern partially matched → all outputs 0 immediately. After release, a new start plus the full pattern gives exactly one Z.
